reg_bank_shift_unit: RTL and testbench

REG_BANK_SHIFT_UNIT -- requirements
Module: reg_bank_shift_unit

---
 rtl/reg_bank_shift_unit.sv | 45 ++++
 tb/tb_reg_bank_shift_unit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/reg_bank_shift_unit.sv
// 32 x 64-bit register bank (x0 hardwired to zero) with two combinational read
// ports and a shifter on read port 1 whose amount comes from Inst[25:20].
module reg_bank_shift_unit (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        RegWrite,
  input  logic [4:0]  ReadReg1,
  input  logic [4:0]  ReadReg2,
  input  logic [4:0]  WriteReg,
  input  logic [63:0] WriteData,
  output logic [63:0] ReadData1,
  output logic [63:0] ReadData2,
  input  logic [31:0] Inst,
  input  logic [1:0]  ShiftCtl,
  output logic [5:0]  ShiftN,
  output logic [63:0] ShiftOut
);

  logic [63:0] regs [32];

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
    end else if (RegWrite && (WriteReg != '0)) begin
      regs[WriteReg] <= WriteData;
    end
  end

  // x0 is masked on read as well, so it reads zero even before the first reset
  assign ReadData1 = (ReadReg1 == '0) ? '0 : regs[ReadReg1];
  assign ReadData2 = (ReadReg2 == '0) ? '0 : regs[ReadReg2];

  assign ShiftN = Inst[25:20];

  always_comb begin
    ShiftOut = ReadData1;
    case (ShiftCtl)
      2'b00:   ShiftOut = ReadData1 << ShiftN;
      2'b01:   ShiftOut = ReadData1 >> ShiftN;
      2'b10:   ShiftOut = $unsigned($signed(ReadData1) >>> ShiftN);
      default: ShiftOut = ReadData1;
    endcase
  end

endmodule

// File: tb/tb_reg_bank_shift_unit.sv
// Directed bench for reg_bank_shift_unit: register-file reset/write/read
// sequences plus a table of shifter vectors with hand-computed results.
module tb_reg_bank_shift_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        RegWrite;
  logic [4:0]  ReadReg1, ReadReg2, WriteReg;
  logic [63:0] WriteData;
  logic [63:0] ReadData1, ReadData2;
  logic [31:0] Inst;
  logic [1:0]  ShiftCtl;
  logic [5:0]  ShiftN;
  logic [63:0] ShiftOut;

  int total = 0;
  int bad   = 0;

  reg_bank_shift_unit dut (
    .Clk(Clk), .Reset(Reset), .RegWrite(RegWrite),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .WriteReg(WriteReg),
    .WriteData(WriteData), .ReadData1(ReadData1), .ReadData2(ReadData2),
    .Inst(Inst), .ShiftCtl(ShiftCtl), .ShiftN(ShiftN), .ShiftOut(ShiftOut)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [63:0] data;
    logic [5:0]  shamt;
    logic [1:0]  ctl;
    logic [63:0] expShift;
  } shiftVec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic writeReg(input logic [4:0] idx, input logic [63:0] data);
    RegWrite  = 1'b1;
    WriteReg  = idx;
    WriteData = data;
    tick();
    RegWrite  = 1'b0;
  endtask

  shiftVec_t vecs [12];

  initial begin
    vecs[0]  = '{64'h8000000000000001, 6'd4,  2'b00, 64'h0000000000000010};
    vecs[1]  = '{64'h8000000000000001, 6'd4,  2'b01, 64'h0800000000000000};
    vecs[2]  = '{64'h8000000000000001, 6'd4,  2'b10, 64'hF800000000000000};
    vecs[3]  = '{64'h8000000000000001, 6'd4,  2'b11, 64'h8000000000000001};
    vecs[4]  = '{64'h8000000000000000, 6'd63, 2'b10, 64'hFFFFFFFFFFFFFFFF};
    vecs[5]  = '{64'h8000000000000000, 6'd63, 2'b01, 64'h0000000000000001};
    vecs[6]  = '{64'h0000000000000001, 6'd63, 2'b00, 64'h8000000000000000};
    vecs[7]  = '{64'h0123456789ABCDEF, 6'd8,  2'b00, 64'h23456789ABCDEF00};
    vecs[8]  = '{64'h0123456789ABCDEF, 6'd8,  2'b10, 64'h000123456789ABCD};
    vecs[9]  = '{64'hFFFF000000000000, 6'd16, 2'b10, 64'hFFFFFFFF00000000};
    vecs[10] = '{64'hDEADBEEF00000000, 6'd32, 2'b01, 64'h00000000DEADBEEF};
    vecs[11] = '{64'h8000000000000000, 6'd0,  2'b10, 64'h8000000000000000};

    Reset = 1'b0; RegWrite = 1'b0;
    ReadReg1 = '0; ReadReg2 = '0; WriteReg = '0; WriteData = '0;
    Inst = 32'h0; ShiftCtl = 2'b00;
    tick();
    Reset = 1'b1;

    for (int i = 0; i < 32; i++) begin
      ReadReg1 = 5'(i);
      ReadReg2 = 5'(31 - i);
      #1;
      check($sformatf("reset_rd1_x%0d", i), ReadData1, 64'h0);
      check($sformatf("reset_rd2_x%0d", 31 - i), ReadData2, 64'h0);
    end
    ReadReg1 = '0;
    #1;
    check("reset_shiftout", ShiftOut, 64'h0);

    // Read-during-write: old value before the edge, new value after
    ReadReg1 = 5'd5; ReadReg2 = 5'd5;
    RegWrite = 1'b1; WriteReg = 5'd5; WriteData = 64'h0123456789ABCDEF;
    #1;
    check("x5_before_edge_rd1", ReadData1, 64'h0);
    check("x5_before_edge_rd2", ReadData2, 64'h0);
    tick();
    RegWrite = 1'b0;
    check("x5_after_edge_rd1", ReadData1, 64'h0123456789ABCDEF);
    check("x5_after_edge_rd2", ReadData2, 64'h0123456789ABCDEF);

    writeReg(5'd0, 64'hFFFFFFFFFFFFFFFF);
    ReadReg1 = 5'd0; ReadReg2 = 5'd0;
    #1;
    check("x0_write_ignored_rd1", ReadData1, 64'h0);
    check("x0_write_ignored_rd2", ReadData2, 64'h0);

    RegWrite = 1'b0; WriteReg = 5'd3; WriteData = 64'hA5A5A5A5A5A5A5A5;
    tick();
    ReadReg1 = 5'd3; ReadReg2 = 5'd5;
    #1;
    check("regwrite0_x3", ReadData1, 64'h0);
    check("indep_port2_x5", ReadData2, 64'h0123456789ABCDEF);

    writeReg(5'd31, 64'h1122334455667788);
    ReadReg1 = 5'd31; ReadReg2 = 5'd5;
    #1;
    check("x31_rd1", ReadData1, 64'h1122334455667788);
    check("x5_rd2_unchanged", ReadData2, 64'h0123456789ABCDEF);

    // Shifter vectors: load x1, then drive shamt with noise in the other Inst bits
    for (int i = 0; i < 12; i++) begin
      writeReg(5'd1, vecs[i].data);
      ReadReg1 = 5'd1;
      Inst     = {6'b101010, vecs[i].shamt, 20'hABCDE};
      ShiftCtl = vecs[i].ctl;
      #1;
      check($sformatf("shiftn_v%0d", i), {58'h0, ShiftN}, {58'h0, vecs[i].shamt});
      check($sformatf("shiftout_v%0d", i), ShiftOut, vecs[i].expShift);
    end

    // Reset overrides a simultaneous write and clears earlier contents
    Reset = 1'b0;
    RegWrite = 1'b1; WriteReg = 5'd7; WriteData = 64'hCAFEF00DCAFEF00D;
    tick();
    Reset = 1'b1; RegWrite = 1'b0;
    ReadReg1 = 5'd7; ReadReg2 = 5'd5;
    #1;
    check("reset_beats_write_x7", ReadData1, 64'h0);
    check("reset_clears_x5", ReadData2, 64'h0);
    ReadReg1 = 5'd1; ShiftCtl = 2'b11;
    #1;
    check("post_reset_shiftout", ShiftOut, 64'h0);

    writeReg(5'd7, 64'h0000000000000077);
    ReadReg1 = 5'd7;
    #1;
    check("first_write_after_reset_x7", ReadData1, 64'h0000000000000077);

    // Reset held low without an edge does nothing
    Reset = 1'b0;
    #2;
    check("async_reset_no_effect", ReadData1, 64'h0000000000000077);
    Reset = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
